// File: rtl/bpu_dyn.sv
// Dynamic branch predictor for the decode stage.
// Combinational prediction from a 2-bit counter table (bimodal or gshare
// index), a global history register trained at resolve, and a circular
// return-address stack for call/return pairs.
//
// Lookup/update semantics: i_lkp_vld qualifies the decoded instruction in
// the current cycle. The prediction outputs are combinational and valid
// whenever i_lkp_vld is high. The RAS only changes for an accepted lookup
// (i_lkp_vld & ~i_stop & ~i_flush); there is no ready/backpressure, the
// predictor always accepts. i_upd_vld is a single-cycle fire-and-forget
// training strobe and is never gated by stall or flush.
module bpu_dyn #(
    parameter int BHT_IDX_W = 8,
    parameter int GHR_W     = 8,
    parameter int MODE      = 1,
    parameter int RAS_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stop,
    input  logic                 i_flush,
    input  logic                 i_lkp_vld,
    input  logic [XLEN-1:0]      i_pc,
    input  logic                 i_inst_jal,
    input  logic                 i_inst_jalr,
    input  logic                 i_inst_bxx,
    input  logic [4:0]           i_rdidx,
    input  logic [4:0]           i_rs1idx,
    input  logic [XLEN-1:0]      i_imm,
    input  logic [XLEN-1:0]      i_jalr_rs1rdata,
    output logic                 o_prdt_taken,
    output logic [XLEN-1:0]      o_prdt_pc,
    output logic [BHT_IDX_W-1:0] o_prdt_idx,
    input  logic                 i_upd_vld,
    input  logic [BHT_IDX_W-1:0] i_upd_idx,
    input  logic                 i_upd_taken
);

    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int TOS_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    // Predictor state. Names kept short and stable so checkers can bind.
    logic [1:0]       bht [BHT_N];
    logic [GHR_W-1:0] ghr;
    logic [XLEN-1:0]  ras [RAS_DEPTH];
    logic [TOS_W-1:0] tos;
    logic [CNT_W-1:0] ras_cnt;

    // ------------------------------------------------------------------
    // Index generation
    // ------------------------------------------------------------------
    logic [BHT_IDX_W-1:0] pc_idx;
    logic [BHT_IDX_W-1:0] ghr_ext;
    logic [BHT_IDX_W-1:0] lkp_idx;

    assign pc_idx = i_pc[BHT_IDX_W+1:2];

    // Zero-extend the history to the index width.
    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_W-1:0] = ghr;
    end

    generate
        if (MODE == 0) begin : g_bimodal
            assign lkp_idx = pc_idx;
        end else begin : g_gshare
            assign lkp_idx = pc_idx ^ ghr_ext;
        end
    endgenerate

    assign o_prdt_idx = lkp_idx;

    // ------------------------------------------------------------------
    // Call / return classification
    // ------------------------------------------------------------------
    logic rd_link;
    logic rs1_link;
    logic is_call;
    logic is_ret;
    logic is_pop;
    logic ras_empty;
    logic accept;
    logic do_push;
    logic do_pop;

    assign rd_link   = (i_rdidx == 5'd1) || (i_rdidx == 5'd5);
    assign rs1_link  = (i_rs1idx == 5'd1) || (i_rs1idx == 5'd5);
    assign is_call   = (i_inst_jal | i_inst_jalr) & rd_link;
    // Pure return: link source, non-link destination.
    assign is_ret    = i_inst_jalr & rs1_link & ~rd_link;
    // Any jalr reading a link register pops; with a link rd it also pushes,
    // which replaces the top entry (coroutine swap).
    assign is_pop    = i_inst_jalr & rs1_link;
    assign ras_empty = (ras_cnt == '0);
    assign accept    = i_lkp_vld & ~i_stop & ~i_flush;
    assign do_push   = accept & is_call;
    assign do_pop    = accept & is_pop;

    // ------------------------------------------------------------------
    // Targets
    // ------------------------------------------------------------------
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] ret_addr;
    logic [XLEN-1:0] ras_top;

    assign br_tgt   = i_pc + i_imm;
    assign jalr_sum = i_jalr_rs1rdata + i_imm;
    assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
    assign ret_addr = i_pc + XLEN'(4);
    assign ras_top  = ras[tos];

    // Prediction: branch class priority bxx > jal > jalr, zero when idle.
    always_comb begin
        o_prdt_taken = 1'b0;
        o_prdt_pc    = '0;
        if (i_lkp_vld) begin
            if (i_inst_bxx) begin
                o_prdt_taken = bht[lkp_idx][1];
                o_prdt_pc    = br_tgt;
            end else if (i_inst_jal) begin
                o_prdt_taken = 1'b1;
                o_prdt_pc    = br_tgt;
            end else if (i_inst_jalr) begin
                o_prdt_taken = 1'b1;
                o_prdt_pc    = (is_ret && !ras_empty) ? ras_top : jalr_tgt;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAS next state: pop first (if non-empty), then push on top of that.
    // ------------------------------------------------------------------
    logic [TOS_W-1:0] pop_tos;
    logic [CNT_W-1:0] pop_cnt;
    logic [TOS_W-1:0] push_ptr;
    logic [TOS_W-1:0] nxt_tos;
    logic [CNT_W-1:0] nxt_cnt;

    // Compose pop and push into one pointer/occupancy update.
    always_comb begin
        pop_tos = tos;
        pop_cnt = ras_cnt;
        if (do_pop && !ras_empty) begin
            pop_tos = tos - TOS_W'(1);
            pop_cnt = ras_cnt - CNT_W'(1);
        end
        push_ptr = pop_tos + TOS_W'(1);
        nxt_tos  = pop_tos;
        nxt_cnt  = pop_cnt;
        if (do_push) begin
            nxt_tos = push_ptr;
            // Occupancy saturates; the pointer wraps and overwrites the oldest.
            if (pop_cnt != RAS_FULL) begin
                nxt_cnt = pop_cnt + CNT_W'(1);
            end
        end
    end

    // RAS pointer and occupancy registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tos     <= '0;
            ras_cnt <= '0;
        end else begin
            tos     <= nxt_tos;
            ras_cnt <= nxt_cnt;
        end
    end

    // RAS storage: write the return address at the new top on a push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else if (do_push) begin
            ras[push_ptr] <= ret_addr;
        end
    end

    // ------------------------------------------------------------------
    // Training at resolve
    // ------------------------------------------------------------------

    // Counter table: saturating move toward the resolved direction.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (i_upd_vld) begin
            if (i_upd_taken && (bht[i_upd_idx] != 2'b11)) begin
                bht[i_upd_idx] <= bht[i_upd_idx] + 2'b01;
            end else if (!i_upd_taken && (bht[i_upd_idx] != 2'b00)) begin
                bht[i_upd_idx] <= bht[i_upd_idx] - 2'b01;
            end
        end
    end

    // Global history: shift in each resolved direction, never rolled back.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ghr <= '0;
        end else if (i_upd_vld) begin
            ghr <= (ghr << 1) | GHR_W'(i_upd_taken);
        end
    end

endmodule

// File: tb/tb_bpu_dyn.sv
// Self-checking bench for bpu_dyn: one bimodal and one gshare instance share
// the same stimulus; predictions are checked through an expected queue.
module tb_bpu_dyn;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop, flush, lkp_vld;
  logic [31:0] pc, imm, rs1data;
  logic        jal, jalr, bxx;
  logic [4:0]  rdidx, rs1idx;
  logic        upd_vld, upd_taken;
  logic [7:0]  upd_idx;

  logic        taken0, taken1;
  logic [31:0] pc0, pc1;
  logic [7:0]  idx0, idx1;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [32:0] exp_g_q[$];
  logic [32:0] exp_v, got_v;

  bpu_dyn #(.BHT_IDX_W(8), .GHR_W(8), .MODE(0), .RAS_DEPTH(4), .XLEN(32)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_stop(stop), .i_flush(flush), .i_lkp_vld(lkp_vld),
    .i_pc(pc), .i_inst_jal(jal), .i_inst_jalr(jalr), .i_inst_bxx(bxx),
    .i_rdidx(rdidx), .i_rs1idx(rs1idx), .i_imm(imm), .i_jalr_rs1rdata(rs1data),
    .o_prdt_taken(taken0), .o_prdt_pc(pc0), .o_prdt_idx(idx0),
    .i_upd_vld(upd_vld), .i_upd_idx(upd_idx), .i_upd_taken(upd_taken)
  );

  bpu_dyn #(.BHT_IDX_W(8), .GHR_W(8), .MODE(1), .RAS_DEPTH(4), .XLEN(32)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_stop(stop), .i_flush(flush), .i_lkp_vld(lkp_vld),
    .i_pc(pc), .i_inst_jal(jal), .i_inst_jalr(jalr), .i_inst_bxx(bxx),
    .i_rdidx(rdidx), .i_rs1idx(rs1idx), .i_imm(imm), .i_jalr_rs1rdata(rs1data),
    .o_prdt_taken(taken1), .o_prdt_pc(pc1), .o_prdt_idx(idx1),
    .i_upd_vld(upd_vld), .i_upd_idx(upd_idx), .i_upd_taken(upd_taken)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // driver tasks
  task automatic idle_inputs();
    lkp_vld = 0; stop = 0; flush = 0; pc = 0; imm = 0; rs1data = 0;
    jal = 0; jalr = 0; bxx = 0; rdidx = 0; rs1idx = 0;
    upd_vld = 0; upd_idx = 0; upd_taken = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic drive_lkp(input logic j, input logic jr, input logic b,
                           input logic [31:0] p, input logic [31:0] im,
                           input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [31:0] rdata);
    lkp_vld = 1; jal = j; jalr = jr; bxx = b; pc = p; imm = im;
    rdidx = rd; rs1idx = rs1; rs1data = rdata;
  endtask

  task automatic drive_upd(input logic [7:0] idx, input logic t);
    upd_vld = 1; upd_idx = idx; upd_taken = t;
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    next_cycle();
    exp_q.push_back({1'b0, 32'h0});
    exp_g_q.push_back({1'b0, 32'h0});
    #2;
    got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_out0 got %h exp %h", got_v, exp_v); end
    got_v = {taken1, pc1}; exp_v = exp_g_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_out1 got %h exp %h", got_v, exp_v); end
    checks++;
    if (dut0.ras_cnt !== 3'd0 || dut0.tos !== 2'd0 || dut0.ghr !== 8'h00) begin
      errors++; $display("FAIL reset_state cnt %0d tos %0d ghr %h exp 0 0 00", dut0.ras_cnt, dut0.tos, dut0.ghr);
    end
    checks++;
    if (dut0.bht[0] !== 2'b01 || dut0.bht[255] !== 2'b01) begin
      errors++; $display("FAIL reset_bht got %b %b exp 01 01", dut0.bht[0], dut0.bht[255]);
    end
  endtask

  task automatic test_bimodal();
    int up_t[9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    int up_e[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    do_reset();
    next_cycle();
    drive_lkp(0, 0, 1, 32'h100, 32'h20, 0, 0, 0);
    exp_q.push_back({1'b0, 32'h120});
    #2;
    got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL bim_init got %h exp %h", got_v, exp_v); end
    checks++;
    if (idx0 !== 8'h40) begin errors++; $display("FAIL bim_idx got %h exp 40", idx0); end
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      drive_upd(8'h40, up_t[i][0]);
      next_cycle();
      drive_lkp(0, 0, 1, 32'h100, 32'h20, 0, 0, 0);
      exp_q.push_back({up_e[i][0], 32'h120});
      #2;
      got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL bim_step%0d got %h exp %h", i, got_v, exp_v); end
    end
    // counter is 2: a same-cycle update must not bypass into the lookup
    next_cycle();
    drive_lkp(0, 0, 1, 32'h100, 32'h20, 0, 0, 0);
    drive_upd(8'h40, 1'b0);
    exp_q.push_back({1'b1, 32'h120});
    #2;
    got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL bim_nobypass got %h exp %h", got_v, exp_v); end
    next_cycle();
    drive_lkp(0, 0, 1, 32'h100, 32'h20, 0, 0, 0);
    exp_q.push_back({1'b0, 32'h120});
    #2;
    got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL bim_after_same got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_gshare();
    int pat[8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    do_reset();
    // saturate the counter at 0x4A = 0x40 ^ 0x0A, then shape history to 0x0A
    next_cycle(); drive_upd(8'h4A, 1'b1);
    next_cycle(); drive_upd(8'h4A, 1'b1);
    for (int i = 0; i < 8; i++) begin
      next_cycle(); drive_upd(8'hF0, pat[i][0]);
    end
    next_cycle();
    checks++;
    if (dut1.ghr !== 8'h0A) begin errors++; $display("FAIL gs_ghr got %h exp 0a", dut1.ghr); end
    drive_lkp(0, 0, 1, 32'h100, 32'h20, 0, 0, 0);
    exp_g_q.push_back({1'b1, 32'h120});
    exp_q.push_back({1'b0, 32'h120});
    #2;
    checks++;
    if (idx1 !== 8'h4A) begin errors++; $display("FAIL gs_idx got %h exp 4a", idx1); end
    got_v = {taken1, pc1}; exp_v = exp_g_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL gs_hit got %h exp %h", got_v, exp_v); end
    got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL gs_bimodal_side got %h exp %h", got_v, exp_v); end
    next_cycle(); drive_upd(8'hF0, 1'b0);
    next_cycle();
    drive_lkp(0, 0, 1, 32'h100, 32'h20, 0, 0, 0);
    exp_g_q.push_back({1'b0, 32'h120});
    #2;
    checks++;
    if (idx1 !== 8'h54) begin errors++; $display("FAIL gs_idx2 got %h exp 54", idx1); end
    got_v = {taken1, pc1}; exp_v = exp_g_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL gs_other_ghr got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_call_return();
    logic [32:0] e[7] = '{{1'b1, 32'h240}, {1'b1, 32'h204}, {1'b1, 32'hDEB0},
                          {1'b1, 32'h200}, {1'b0, 32'h0}, {1'b0, 32'h0}, {1'b0, 32'hF8}};
    int ec[7] = '{1, 0, 0, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      case (i)
        0: drive_lkp(1, 0, 0, 32'h200, 32'h40, 5'd1, 5'd0, 32'h0);
        1: drive_lkp(0, 1, 0, 32'h300, 32'h0, 5'd0, 5'd1, 32'hDEAD);
        2: drive_lkp(0, 1, 0, 32'h300, 32'h4, 5'd0, 5'd1, 32'hDEAD);
        3: drive_lkp(1, 0, 0, 32'h210, 32'hFFFF_FFF0, 5'd0, 5'd0, 32'h0);
        4: drive_lkp(0, 0, 0, 32'h220, 32'h8, 5'd1, 5'd1, 32'h0);
        5: begin drive_lkp(1, 0, 0, 32'h230, 32'h8, 5'd1, 5'd0, 32'h0); lkp_vld = 0; end
        default: drive_lkp(0, 0, 1, 32'h100, 32'hFFFF_FFF8, 5'd0, 5'd0, 32'h0);
      endcase
      exp_q.push_back(e[i]);
      #2;
      got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL cr_step%0d got %h exp %h", i, got_v, exp_v); end
      next_cycle();
      checks++;
      if (dut0.ras_cnt !== 3'(ec[i])) begin
        errors++; $display("FAIL cr_cnt%0d got %0d exp %0d", i, dut0.ras_cnt, ec[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e[6] = '{{1'b1, 32'h410}, {1'b1, 32'h1008}, {1'b1, 32'h504},
                          {1'b1, 32'h720}, {1'b1, 32'h704}, {1'b1, 32'h3000}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      case (i)
        0: drive_lkp(1, 0, 0, 32'h400, 32'h10, 5'd5, 5'd0, 32'h0);
        1: drive_lkp(0, 1, 0, 32'h500, 32'h8, 5'd1, 5'd5, 32'h1000);
        2: drive_lkp(0, 1, 0, 32'h600, 32'h0, 5'd0, 5'd1, 32'h2000);
        3: drive_lkp(1, 0, 0, 32'h700, 32'h20, 5'd1, 5'd0, 32'h0);
        4: drive_lkp(0, 1, 0, 32'h780, 32'h0, 5'd0, 5'd5, 32'h2000);
        default: drive_lkp(0, 1, 0, 32'h800, 32'h0, 5'd1, 5'd1, 32'h3001);
      endcase
      exp_q.push_back(e[i]);
      #2;
      got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL b2b_step%0d got %h exp %h", i, got_v, exp_v); end
    end
    // pop on empty is a no-op, then the push leaves one entry: 0x804
    next_cycle();
    checks++;
    if (dut0.ras_cnt !== 3'd1) begin errors++; $display("FAIL b2b_cnt got %0d exp 1", dut0.ras_cnt); end
    drive_lkp(0, 1, 0, 32'h900, 32'h0, 5'd0, 5'd1, 32'h5000);
    exp_q.push_back({1'b1, 32'h804});
    #2;
    got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL b2b_swap_ret got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] ret_e[6] = '{32'h64, 32'h54, 32'h44, 32'h34, 32'h3000, 32'h3000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive_lkp(1, 0, 0, 32'(16 * (i + 1)), 32'h100, 5'd1, 5'd0, 32'h0);
      exp_q.push_back({1'b1, 32'(16 * (i + 1) + 32'h100)});
      #2;
      got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL ovf_call%0d got %h exp %h", i, got_v, exp_v); end
    end
    next_cycle();
    checks++;
    if (dut0.ras_cnt !== 3'd4) begin errors++; $display("FAIL ovf_cnt got %0d exp 4", dut0.ras_cnt); end
    for (int i = 0; i < 6; i++) begin
      if (i != 0) next_cycle();
      drive_lkp(0, 1, 0, 32'h1000, 32'h0, 5'd0, 5'd1, 32'h3001);
      exp_q.push_back({1'b1, ret_e[i]});
      #2;
      got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL ovf_ret%0d got %h exp %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive_lkp(1, 0, 0, 32'h900, 32'h10, 5'd1, 5'd0, 32'h0);
      if (i == 0) stop = 1; else flush = 1;
      exp_q.push_back({1'b1, 32'h910});
      #2;
      got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL sf_call%0d got %h exp %h", i, got_v, exp_v); end
      next_cycle();
      checks++;
      if (dut0.ras_cnt !== 3'd0) begin errors++; $display("FAIL sf_cnt%0d got %0d exp 0", i, dut0.ras_cnt); end
    end
    // accepted call, then a stalled return must not pop
    drive_lkp(1, 0, 0, 32'h900, 32'h10, 5'd1, 5'd0, 32'h0);
    next_cycle();
    drive_lkp(0, 1, 0, 32'hA00, 32'h0, 5'd0, 5'd1, 32'h7000);
    stop = 1;
    exp_q.push_back({1'b1, 32'h904});
    #2;
    got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL sf_ret got %h exp %h", got_v, exp_v); end
    next_cycle();
    checks++;
    if (dut0.ras_cnt !== 3'd1) begin errors++; $display("FAIL sf_ret_cnt got %0d exp 1", dut0.ras_cnt); end
    // training ignores flush and stall
    flush = 1; stop = 1;
    drive_upd(8'h10, 1'b1);
    next_cycle();
    drive_lkp(0, 0, 1, 32'h40, 32'h4, 5'd0, 5'd0, 32'h0);
    exp_q.push_back({1'b1, 32'h44});
    #2;
    got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL sf_train got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive_lkp(1, 0, 0, 32'(32'hA0 + 16 * i), 32'h8, 5'd1, 5'd0, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive_upd(8'h20, 1'b1);
    end
    next_cycle();
    checks++;
    if (dut0.ras_cnt !== 3'd3 || dut0.bht[8'h20] !== 2'b11) begin
      errors++; $display("FAIL rm_pre got cnt %0d bht %b exp 3 11", dut0.ras_cnt, dut0.bht[8'h20]);
    end
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (dut0.ras_cnt !== 3'd0 || dut0.tos !== 2'd0 || dut0.ghr !== 8'h00 || dut0.bht[8'h20] !== 2'b01) begin
      errors++;
      $display("FAIL rm_state got cnt %0d tos %0d ghr %h bht %b exp 0 0 00 01",
               dut0.ras_cnt, dut0.tos, dut0.ghr, dut0.bht[8'h20]);
    end
    next_cycle();
    drive_lkp(0, 1, 0, 32'hB00, 32'h0, 5'd0, 5'd1, 32'h889);
    exp_q.push_back({1'b1, 32'h888});
    #2;
    got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rm_ret got %h exp %h", got_v, exp_v); end
    next_cycle();
    drive_lkp(0, 0, 1, 32'h80, 32'h10, 5'd0, 5'd0, 32'h0);
    exp_q.push_back({1'b0, 32'h90});
    #2;
    got_v = {taken0, pc0}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rm_bxx got %h exp %h", got_v, exp_v); end
  endtask

  // sequence and final report
  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_bimodal();
    test_gshare();
    test_call_return();
    test_back_to_back();
    test_ras_overflow();
    test_stall_flush();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || exp_g_q.size() != 0) begin
      errors++; $display("FAIL queue_drain got %0d %0d exp 0 0", exp_q.size(), exp_g_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
